sprite_renderer: RTL and testbench
==================================

Name: sprite_renderer

Overview:
- Consumer end of the player sprite interface: takes the sprite id, mirror flag, size and screen position that the player/object logic produces, and turns them into per-pixel colour for the VGA path.
- Sits between the VGA timing generator, which supplies scan coordinates, and the colour mux.
- Fetches texels from the shared sprite ROM through a fixed-latency pipeline and flags opaque hits so the mux can overlay the sprite on the background.

Parameters:
- ADDR_W, 18, sprite ROM word-address width
- COLOR_W, 12, RGB444 texel width
- TRANSPARENT, 12'hF0F, texel value treated as see-through
- NULL_ID, 63, sprite id meaning "draw nothing"
- ERR_ID, 32, invalid-state id; also draws nothing

Ports:
- clk, in, 1, system clock
- rstn, in, 1, reset. Asynchronous, active-low.
- frame_start, in, 1, one-cycle pulse at the start of vertical blank
- pix_valid, in, 1, scan coordinate below is valid this cycle
- col, in, 11, current scan column
- row, in, 11, current scan row
- sprite_id, in, 6, sprite to draw
- mirror, in, 1, 1 = flip horizontally (facing left, using a right-facing texture)
- sprite_x, in, 11, top-left column of the sprite
- sprite_y, in, 11, top-left row of the sprite
- w, in, 11, sprite width in pixels
- h, in, 11, sprite height in pixels
- rom_rd, out, 1, ROM read strobe
- rom_addr, out, ADDR_W, ROM word address
- rom_data, in, COLOR_W, ROM data, valid exactly 1 cycle after rom_rd
- px_valid, out, 1, output pixel valid
- px_hit, out, 1, opaque sprite texel at this pixel
- px_color, out, COLOR_W, texel colour; 0 when px_hit = 0
- hit_count, out, 22, opaque pixels drawn in the previous frame

Behaviour:
- Reset values:
  - All outputs 0.
  - Latched attributes: id = NULL_ID, everything else 0.
  - Pipeline valid bits cleared.
  - Frame hit accumulator 0.
- Attribute latch:
  - On frame_start, latch sprite_id, mirror, sprite_x, sprite_y, w and h. This prevents mid-frame tearing.
  - If frame_start coincides with pix_valid, that pixel uses the old attributes; the new ones apply from the next cycle.
- Stage S0, hit test and address, registered:
  - in = pix_valid, id not NULL_ID/ERR_ID, w != 0, h != 0, col in [sx, sx+w), row in [sy, sy+h).
  - Compare in 12 bits so that sx+w never wraps.
  - dx = col - sx; dy = row - sy; tx = mirror ? (w-1-dx) : dx.
  - rom_addr = base(id) + dy*w + tx, where dy*w is 22 bits, truncated to ADDR_W.
  - rom_rd = in.
- Stage S1: ROM returns rom_data. Carry valid/in alongside.
- Stage S2, output register:
  - px_valid = delayed pix_valid.
  - px_hit = in & (rom_data != TRANSPARENT).
  - px_color = px_hit ? rom_data : 0.
- Latency: exactly 3 cycles from pix_valid to px_valid, independent of hit. One pixel per cycle; no stalls, no backpressure.
- Hit counter:
  - Increment the accumulator on each px_hit, saturating at 2^22-1.
  - On frame_start, copy it to hit_count and clear it.
  - If a hit coincides with frame_start, that hit counts toward the new frame.
- Consecutive pix_valid cycles are fully pipelined. Gaps propagate as px_valid = 0.
- Reset asserted mid-line: the pipeline flushes immediately. No px_valid until 3 cycles after the first post-reset pix_valid. Sprite is NULL until the next frame_start.

Decomposition:
- Shared package sprite_pkg:
  - Id constants: NULL_ID, ERR_ID, and the player ids 15–20 and 26–31.
  - TRANSPARENT.
  - Function sprite_base(id) → ADDR_W base address table, shared with the ROM init script.
- One sub-module, sprite_hit_addr: combinational S0 math (range compare, mirror, dy*w + tx + base). It is instantiated once here and reused later for enemy sprites.

Test Plan:
- Reset then frame_start with id=16, x=100, y=200, w=40, h=42, mirror=0; scan row 200, cols 99..140 → px_hit=0 at col 99 and 140. Texel at col 100 = ROM[base(16)+0], at col 139 = ROM[base(16)+39]. px_valid lags pix_valid by 3 cycles.
- Same setup with mirror=1 → col 100 reads ROM[base+39], col 139 reads base+0. Row 241, col 100 reads base + 41*40 + 39.
- id=63, then id=32, each latched with valid geometry → rom_rd never asserted, px_hit=0 over the full frame, hit_count=0 after the next frame_start.
- Change sprite_x mid-frame without frame_start → output geometry unchanged until frame_start. frame_start coincident with pix_valid → that pixel uses the old geometry.
- ROM model returns TRANSPARENT for the even texels of a 4x4 sprite → 8 hits, px_color 0 on the misses. hit_count=8 after the next frame_start.
- sprite_x=2040, w=45 → hits at cols 2040..2047 with no wrap to col 0. Assert rstn low mid-row → px_valid and px_hit drop at once; no hits until a new frame_start.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite ids, transparency key and ROM base table
package sprite_pkg;

    localparam int ADDR_W  = 18;
    localparam int COLOR_W = 12;

    localparam logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F;

    localparam logic [5:0] NULL_ID = 6'd63;
    localparam logic [5:0] ERR_ID  = 6'd32;

    // Player animation frames occupy two contiguous id ranges.
    localparam logic [5:0] PLAYER_A_FIRST = 6'd15;
    localparam logic [5:0] PLAYER_A_LAST  = 6'd20;
    localparam logic [5:0] PLAYER_B_FIRST = 6'd26;
    localparam logic [5:0] PLAYER_B_LAST  = 6'd31;

    // Each id owns a 4096-texel slot; the ROM init script packs images the same way.
    function automatic logic [ADDR_W-1:0] sprite_base(input logic [5:0] id);
        return {id, 12'h000};
    endfunction

    function automatic logic is_player_id(input logic [5:0] id);
        return ((id >= PLAYER_A_FIRST) && (id <= PLAYER_A_LAST)) ||
               ((id >= PLAYER_B_FIRST) && (id <= PLAYER_B_LAST));
    endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// rtl/sprite_hit_addr.sv - combinational sprite hit test and texel address
//
// Ports:
//   pix_valid_i        scan coordinate valid
//   col_i, row_i       scan coordinate
//   id_i, mirror_i     sprite id and horizontal flip
//   sx_i, sy_i         sprite top-left corner
//   w_i, h_i           sprite size
//   in_o               coordinate lies inside a drawable sprite
//   addr_o             sprite ROM word address of the texel
module sprite_hit_addr #(
    parameter int         ADDR_W  = sprite_pkg::ADDR_W,
    parameter logic [5:0] NULL_ID = sprite_pkg::NULL_ID,
    parameter logic [5:0] ERR_ID  = sprite_pkg::ERR_ID
) (
    input  logic              pix_valid_i,
    input  logic [10:0]       col_i,
    input  logic [10:0]       row_i,
    input  logic [5:0]        id_i,
    input  logic              mirror_i,
    input  logic [10:0]       sx_i,
    input  logic [10:0]       sy_i,
    input  logic [10:0]       w_i,
    input  logic [10:0]       h_i,
    output logic              in_o,
    output logic [ADDR_W-1:0] addr_o
);
    import sprite_pkg::*;

    logic [11:0] x_end;
    logic [11:0] y_end;
    logic        in_x;
    logic        in_y;
    logic        id_ok;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] tx;
    logic [21:0] dy_w;

    // One extra bit so a sprite hanging off the right/bottom edge never wraps to 0.
    assign x_end = {1'b0, sx_i} + {1'b0, w_i};
    assign y_end = {1'b0, sy_i} + {1'b0, h_i};

    assign in_x  = ({1'b0, col_i} >= {1'b0, sx_i}) && ({1'b0, col_i} < x_end);
    assign in_y  = ({1'b0, row_i} >= {1'b0, sy_i}) && ({1'b0, row_i} < y_end);
    assign id_ok = (id_i != NULL_ID) && (id_i != ERR_ID);

    assign in_o  = pix_valid_i && id_ok && (w_i != 11'd0) && (h_i != 11'd0) && in_x && in_y;

    assign dx    = col_i - sx_i;
    assign dy    = row_i - sy_i;
    // Textures face right; a left-facing sprite reads each row back to front.
    assign tx    = mirror_i ? (w_i - 11'd1 - dx) : dx;
    assign dy_w  = {11'd0, dy} * {11'd0, w_i};

    assign addr_o = ADDR_W'(22'(sprite_base(id_i)) + dy_w + {11'd0, tx});

endmodule

// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - sprite texel fetch pipeline and opaque-hit flagging
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   frame_start                 vertical-blank pulse; latches sprite attributes
//   pix_valid, col, row         scan coordinate from VGA timing
//   sprite_id, mirror,
//   sprite_x, sprite_y, w, h    sprite attributes from player/object logic
//   rom_rd, rom_addr            sprite ROM read request
//   rom_data                    ROM texel, one cycle after rom_rd
//   px_valid, px_hit, px_color  output pixel, 3 cycles after pix_valid
//   hit_count                   opaque pixels drawn in the previous frame
module sprite_renderer #(
    parameter int                 ADDR_W      = sprite_pkg::ADDR_W,
    parameter int                 COLOR_W     = sprite_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] TRANSPARENT = sprite_pkg::TRANSPARENT,
    parameter logic [5:0]         NULL_ID     = sprite_pkg::NULL_ID,
    parameter logic [5:0]         ERR_ID      = sprite_pkg::ERR_ID
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [10:0]        col,
    input  logic [10:0]        row,
    input  logic [5:0]         sprite_id,
    input  logic               mirror,
    input  logic [10:0]        sprite_x,
    input  logic [10:0]        sprite_y,
    input  logic [10:0]        w,
    input  logic [10:0]        h,
    output logic               rom_rd,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               px_valid,
    output logic               px_hit,
    output logic [COLOR_W-1:0] px_color,
    output logic [21:0]        hit_count
);
    import sprite_pkg::*;

    // Attributes held for the whole frame so a mid-frame update cannot tear.
    logic [5:0]         id_q;
    logic               mirror_q;
    logic [10:0]        sx_q;
    logic [10:0]        sy_q;
    logic [10:0]        w_q;
    logic [10:0]        h_q;

    logic               s0_valid_q;
    logic               rom_rd_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic               s1_valid_q;
    logic               s1_in_q;
    logic               px_valid_q;
    logic               px_hit_q;
    logic [COLOR_W-1:0] px_color_q;
    logic [21:0]        acc_q;
    logic [21:0]        hit_count_q;

    logic               in_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               px_hit_d;
    logic [COLOR_W-1:0] px_color_d;
    logic [21:0]        acc_d;

    sprite_hit_addr #(
        .ADDR_W  (ADDR_W),
        .NULL_ID (NULL_ID),
        .ERR_ID  (ERR_ID)
    ) u_hit_addr (
        .pix_valid_i (pix_valid),
        .col_i       (col),
        .row_i       (row),
        .id_i        (id_q),
        .mirror_i    (mirror_q),
        .sx_i        (sx_q),
        .sy_i        (sy_q),
        .w_i         (w_q),
        .h_i         (h_q),
        .in_o        (in_d),
        .addr_o      (addr_d)
    );

    always_comb begin
        px_hit_d   = s1_in_q && (rom_data != TRANSPARENT);
        px_color_d = px_hit_d ? rom_data : '0;
        acc_d      = (px_hit_q && (acc_q != '1)) ? acc_q + 22'd1 : acc_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q        <= NULL_ID;
            mirror_q    <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            s0_valid_q  <= 1'b0;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_in_q     <= 1'b0;
            px_valid_q  <= 1'b0;
            px_hit_q    <= 1'b0;
            px_color_q  <= '0;
            acc_q       <= '0;
            hit_count_q <= '0;
        end else begin
            // A pixel sampled together with frame_start still sees the old attributes.
            if (frame_start) begin
                id_q     <= sprite_id;
                mirror_q <= mirror;
                sx_q     <= sprite_x;
                sy_q     <= sprite_y;
                w_q      <= w;
                h_q      <= h;
            end

            // S0: hit test and address
            s0_valid_q <= pix_valid;
            rom_rd_q   <= in_d;
            if (in_d) begin
                rom_addr_q <= addr_d;
            end

            // S1: ROM access in flight
            s1_valid_q <= s0_valid_q;
            s1_in_q    <= rom_rd_q;

            // S2: output register
            px_valid_q <= s1_valid_q;
            px_hit_q   <= px_hit_d;
            px_color_q <= px_color_d;

            // A hit presented on the frame_start cycle opens the new frame's count.
            if (frame_start) begin
                hit_count_q <= acc_q;
                acc_q       <= {21'd0, px_hit_q};
            end else begin
                acc_q       <= acc_d;
            end
        end
    end

    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;
    assign px_valid  = px_valid_q;
    assign px_hit    = px_hit_q;
    assign px_color  = px_color_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb/tb_sprite_renderer.sv - scoreboard bench for sprite_renderer
module tb_sprite_renderer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [10:0] col = '0;
    logic [10:0] row = '0;
    logic [5:0]  sprite_id = '0;
    logic        mirror = 1'b0;
    logic [10:0] sprite_x = '0;
    logic [10:0] sprite_y = '0;
    logic [10:0] w = '0;
    logic [10:0] h = '0;
    logic        rom_rd;
    logic [17:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic        px_valid;
    logic        px_hit;
    logic [11:0] px_color;
    logic [21:0] hit_count;

    sprite_renderer dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .col         (col),
        .row         (row),
        .sprite_id   (sprite_id),
        .mirror      (mirror),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .w           (w),
        .h           (h),
        .rom_rd      (rom_rd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .px_valid    (px_valid),
        .px_hit      (px_hit),
        .px_color    (px_color),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

    logic [11:0] rom [0:262143];
    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    bit no_rd = 1'b0;

    // Reference attributes as latched by the last frame_start
    int m_id = 63, m_mir = 0, m_sx = 0, m_sy = 0, m_w = 0, m_h = 0;

    typedef struct { int cyc; bit hit; logic [11:0] color; } exp_t;
    typedef struct { int cyc; int cnt; } hc_t;
    exp_t sb[$];
    hc_t  hc_q[$];
    int   hits_out[$];

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void model_pixel(input int c, input int r, output bit hit, output logic [11:0] color);
        int dx, dy, tx, addr;
        logic [11:0] t;
        hit = 1'b0;
        color = '0;
        if (m_id != 63 && m_id != 32 && m_w > 0 && m_h > 0 &&
            c >= m_sx && c < m_sx + m_w && r >= m_sy && r < m_sy + m_h) begin
            dx = c - m_sx;
            dy = r - m_sy;
            tx = (m_mir != 0) ? (m_w - 1 - dx) : dx;
            addr = (m_id * 4096 + dy * m_w + tx) % 262144;
            t = rom[addr];
            if (t != 12'hF0F) begin
                hit = 1'b1;
                color = t;
            end
        end
    endfunction

    task automatic drive(input bit fs, input bit pv, input int c, input int r);
        bit hit;
        logic [11:0] color;
        int cnt;
        frame_start = fs;
        pix_valid = pv;
        col = 11'(c);
        row = 11'(r);
        if (rstn) begin
            if (pv) begin
                model_pixel(c, r, hit, color);
                sb.push_back(exp_t'{cyc + 3, hit, color});
                if (hit) hits_out.push_back(cyc + 3);
            end
            if (fs) begin
                cnt = 0;
                while (hits_out.size() > 0 && hits_out[0] < cyc) begin
                    void'(hits_out.pop_front());
                    cnt++;
                end
                hc_q.push_back(hc_t'{cyc + 1, cnt});
                m_id = int'(sprite_id);
                m_mir = int'(mirror);
                m_sx = int'(sprite_x);
                m_sy = int'(sprite_y);
                m_w = int'(w);
                m_h = int'(h);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_attr(input int id, input int m, input int x, input int y, input int ww, input int hh);
        sprite_id = 6'(id);
        mirror = m[0];
        sprite_x = 11'(x);
        sprite_y = 11'(y);
        w = 11'(ww);
        h = 11'(hh);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic scan(input int r, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) drive(0, 1, c, r);
    endtask

    task automatic do_reset(input int n, input int c, input int r);
        rstn = 1'b0;
        sb.delete();
        hits_out.delete();
        hc_q.delete();
        m_id = 63; m_mir = 0; m_sx = 0; m_sy = 0; m_w = 0; m_h = 0;
        repeat (n) drive(0, 1, c, r);
        rstn = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            chk({px_valid, px_hit, px_color, hit_count, rom_rd} == '0, "reset_outputs",
                {px_valid, px_hit, px_color, hit_count, rom_rd}, 0);
        end else begin
            if (px_valid) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_px_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk(e.cyc == cyc, "latency_cycle", cyc, e.cyc);
                    chk(px_hit == e.hit, "px_hit", px_hit, e.hit);
                    chk(px_color == e.color, "px_color", px_color, e.color);
                end
            end else begin
                chk(!px_hit && px_color == '0, "idle_outputs", {px_hit, px_color}, 0);
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    chk(1'b0, "missing_px_valid", 0, e.cyc);
                end
            end
            if (no_rd) chk(!rom_rd, "rom_rd_null", rom_rd, 0);
            if (hc_q.size() > 0 && hc_q[0].cyc <= cyc) begin
                hc_t hc;
                hc = hc_q.pop_front();
                chk(hit_count == 22'(hc.cnt), "hit_count", hit_count, hc.cnt);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int ids[14];
        int cc, rr, k;
        for (int i = 0; i < 262144; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
        // Distinct opaque texels at the corners the edge tests look at
        rom[16 * 4096 + 0]            = 12'h123;
        rom[16 * 4096 + 39]           = 12'h456;
        rom[16 * 4096 + 41 * 40 + 39] = 12'h789;
        rom[16 * 4096 + 41 * 40]      = 12'hABC;
        for (int i = 0; i < 16; i++) rom[20 * 4096 + i] = (i % 2 == 0) ? 12'hF0F : 12'(12'h100 + i);
        for (int i = 0; i < 8; i++) rom[26 * 4096 + i] = 12'(12'h0A0 + i);

        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        // Right-facing sprite, edge columns and bottom row
        set_attr(16, 0, 100, 200, 40, 42);
        drive(1, 0, 0, 0);
        scan(200, 99, 140); idle(2);
        scan(241, 98, 141); scan(242, 99, 101); idle(5);

        // Left-facing sprite
        set_attr(16, 1, 100, 200, 40, 42);
        drive(1, 0, 0, 0);
        scan(200, 99, 140); idle(1);
        scan(241, 98, 141); idle(5);

        // NULL then ERR id: nothing drawn, no ROM traffic
        set_attr(63, 0, 100, 200, 40, 42);
        drive(1, 0, 0, 0);
        no_rd = 1'b1;
        scan(200, 95, 145); scan(220, 95, 145); idle(4);
        set_attr(32, 0, 100, 200, 40, 42);
        drive(1, 0, 0, 0);
        scan(200, 95, 145); scan(220, 95, 145); idle(4);
        no_rd = 1'b0;

        // 4x4 sprite with transparent even texels
        set_attr(20, 0, 10, 10, 4, 4);
        drive(1, 0, 0, 0);
        for (int r = 9; r <= 14; r++) scan(r, 8, 15);
        idle(5);

        // Mid-frame attribute change ignored until frame_start
        set_attr(16, 0, 500, 300, 20, 20);
        drive(1, 0, 0, 0);
        scan(305, 495, 525);
        sprite_x = 11'd600;
        scan(305, 495, 525);
        drive(1, 1, 505, 305);
        scan(305, 495, 525); scan(305, 595, 625); idle(5);

        // Right-edge sprite must not wrap to column 0
        set_attr(26, 0, 2040, 5, 45, 3);
        drive(1, 0, 0, 0);
        scan(5, 0, 10); scan(5, 2035, 2047); scan(7, 2038, 2047); idle(5);

        // Frame boundary with a hit landing on the frame_start cycle
        set_attr(16, 0, 100, 200, 40, 42);
        drive(1, 0, 0, 0);
        scan(200, 100, 104);
        drive(0, 1, 105, 200);
        drive(0, 1, 106, 200);
        drive(1, 1, 107, 200);
        scan(200, 108, 112); idle(5);

        // Randomised frames
        ids = '{15, 16, 17, 18, 19, 20, 26, 27, 28, 29, 30, 31, 63, 32};
        set_attr(17, 0, 300, 300, 30, 20);
        drive(1, 0, 0, 0);
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : ids[$urandom_range(0, 13)];
                set_attr(k, int'($urandom_range(0, 1)), int'($urandom_range(0, 2047)),
                         int'($urandom_range(0, 2047)), int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
                cc = 1;
            end else begin
                cc = 0;
            end
            k = int'(sprite_x) + int'($urandom_range(0, int'(w) + 6)) - 3;
            rr = int'(sprite_y) + int'($urandom_range(0, int'(h) + 6)) - 3;
            drive(cc[0], $urandom_range(0, 4) != 0, k & 2047, rr & 2047);
        end
        idle(5);
        drive(1, 0, 0, 0);
        idle(3);

        // Reset mid-row: flush, sprite NULL until next frame_start
        set_attr(16, 0, 100, 200, 40, 42);
        drive(1, 0, 0, 0);
        scan(200, 100, 110);
        do_reset(2, 111, 200);
        scan(200, 100, 130); idle(4);
        drive(1, 0, 0, 0);
        scan(200, 100, 120); idle(5);
        drive(1, 0, 0, 0);
        idle(8);

        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        chk(hc_q.size() == 0, "hit_count_drained", hc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
